param_selection_sort: RTL and testbench
=======================================

# param_selection_sort

Parametrised in-place selection sorter for a packed array of N unsigned DW-bit elements, with a runtime element count and ascending/descending order. It is the next generation of the team's fixed 30×7-bit sorter. It sits between a parallel load source and a consumer, and uses a Start/Done/Ack handshake. The sort takes one comparison per clock, with a dedicated swap cycle after each selection pass.

## Interface
- DW, 7: element width in bits, minimum 1.
- N, 30: array depth, minimum 2.
- CW, $clog2(N+1): width of Count (derived).
- IW, $clog2(N): width of a permutation index (derived).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  begins a sort; sampled only in INI.
- Ack  in  1  releases the result; sampled only in DONE.
- Descend  in  1  sort order: 0 ascending, 1 descending; latched at Start.
- Count  in  CW  number of elements to sort, starting at element 0; latched at Start.
- Ain  in  N*DW  input array; element i is Ain[i*DW +: DW].
- Aout  out  N*DW  working/result array, same packing as Ain.
- PermOut  out  N*IW  original index of each output element; present only with SORT_PERM_EN.
- Done  out  1  result valid; high exactly while in DONE.
- q_Ini, q_Incr, q_Comp, q_Swap, q_Done  out  1 each  one-hot state flags.

## Operation
- States, one-hot: INI, INCR, COMP, SWAP, DONE. Any illegal encoding goes to INI on the next clock.
- **INI**
  - Every cycle: A ← Ain, K ← 0.
  - On Start: latch Descend; latch Count, clamped to N.
  - Next state: DONE if the clamped Count < 2, else INCR.
- **INCR**
  - J ← K+1, Idx ← K.
  - Next state: COMP.
- **COMP**
  - Ascending: if A[J] < A[Idx], Idx ← J. Descending: if A[J] > A[Idx], Idx ← J.
  - Comparison is strict, so ties keep the earlier index.
  - If J == Count−1, go to SWAP; else J ← J+1.
- **SWAP**
  - Exchange A[K] and A[Idx]. If Idx == K, A is unchanged.
  - K ← K+1.
  - Next state: DONE if K == Count−2, else INCR.
- **DONE**
  - Hold A.
  - On Ack, go to INI.
- Elements at indices ≥ Count are loaded from Ain and never modified.
- Start outside INI and Ack outside DONE are ignored.
- All comparisons are unsigned, DW bits wide.
- Internal counters J, K and Idx are CW bits wide. They never exceed Count−1.

## Timing
- Reset values: state INI, A all zero, Done 0, q_Ini 1 and the other q_* flags 0. With SORT_PERM_EN, P[i] = i.
- Reset asserted mid-operation aborts immediately to the reset values above. No partial result is retained.
- Aout follows Ain one clock later while in INI. Aout is stable from DONE entry until INI is re-entered.
- Latency from the Start edge to DONE entry, for n = clamped Count ≥ 2: sum over K = 0…n−2 of (n+1−K) cycles. For n = 4 this is 12 cycles.
- For n < 2, DONE is entered on the clock after Start.
- Done rises in the same cycle that q_Done rises.
- Ack sampled high in DONE gives INI and Done = 0 on the next clock.
- Start and Ack high together in DONE: Ack is honoured and Start is ignored. Start must be re-presented in INI.

## Configuration
- SORT_PERM_EN defined:
  - Adds the PermOut port and a per-element IW-bit register array P.
  - In INI, P[i] ← i.
  - In SWAP, P[K] and P[Idx] are exchanged together with A.
- SORT_PERM_EN undefined: no PermOut port and no P registers. All other behaviour is identical.

## Structure
- Package sort_pkg holds:
  - the state localparams (one-hot, 5 bits);
  - state index constants;
  - the order-select encoding (ASC = 0, DESC = 1).
- Sub-module sort_cmp: a combinational DW-bit comparator with inputs a, b, descend and output better. better is a < b when descend = 0 and a > b when descend = 1. It is instantiated once and feeds the Idx update in COMP.

## Test plan
- DW=7, N=30, Count=4, Descend=0, Ain elements [9,3,7,1,…] → Aout [1,3,7,9]; elements 4–29 equal Ain; Done rises 12 cycles after the Start edge.
- Same Ain with Descend=1 → Aout [9,7,3,1].
- Count=1 and Count=0 → DONE on the next clock; Aout equals Ain.
- Count=31 → clamped to 30; a fully reversed 30..1 input sorts to 1..30 ascending.
- Ack held low for 5 cycles in DONE → Done and Aout stable; Ack=1 → q_Ini=1 and Done=0 on the next clock.
- Reset pulsed mid-COMP → q_Ini=1, Done=0, Aout=0 immediately.
- With SORT_PERM_EN, [9,3,7,1] ascending → PermOut [3,1,2,0].

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants for the parametrised selection sorter.
//   - One-hot state encodings and the bit position of each state flag.
//   - Sort order encoding (ascending / descending).
// No ports; imported by sort_cmp and param_selection_sort.
package sort_pkg;

  localparam int unsigned StateW = 5;

  // Bit position of each state inside the one-hot state vector.
  localparam int unsigned IniBit  = 0;
  localparam int unsigned IncrBit = 1;
  localparam int unsigned CompBit = 2;
  localparam int unsigned SwapBit = 3;
  localparam int unsigned DoneBit = 4;

  localparam logic [StateW-1:0] StIni  = 5'b00001;
  localparam logic [StateW-1:0] StIncr = 5'b00010;
  localparam logic [StateW-1:0] StComp = 5'b00100;
  localparam logic [StateW-1:0] StSwap = 5'b01000;
  localparam logic [StateW-1:0] StDone = 5'b10000;

  localparam logic OrderAsc  = 1'b0;
  localparam logic OrderDesc = 1'b1;

endpackage

// File: rtl/sort_cmp.sv
// Combinational DW-bit unsigned comparator used for the selection step.
// Ports:
//   a, b     : candidate element and current best element
//   descend  : sort order (OrderAsc / OrderDesc)
//   better   : a < b when ascending, a > b when descending (strict)
module sort_cmp
  import sort_pkg::*;
#(
  parameter int unsigned DW = 7
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          descend,
  output logic          better
);

  always_comb begin
    better = 1'b0;
    case (descend)
      OrderAsc:  better = (a < b);
      OrderDesc: better = (a > b);
      default:   better = 1'b0;
    endcase
  end

endmodule

// File: rtl/param_selection_sort.sv
// In-place selection sorter for N unsigned DW-bit elements with a runtime
// element count and selectable order. One comparison per clock, plus one swap
// cycle at the end of every selection pass. Start/Done/Ack handshake.
// Optional feature: define SORT_PERM_EN to track the original index of each
// element and expose it on PermOut.
// Ports:
//   Clk, Reset      : clock, asynchronous active-high reset
//   Start           : begin a sort (sampled only in INI)
//   Ack             : release the result (sampled only in DONE)
//   Descend, Count  : order and element count, latched at Start (Count clamped to N)
//   Ain / Aout      : input / working-result arrays, element i at [i*DW +: DW]
//   PermOut         : original index of each output element (SORT_PERM_EN only)
//   Done            : result valid, high exactly while in DONE
//   q_Ini..q_Done   : one-hot state flags
module param_selection_sort
  import sort_pkg::*;
#(
  parameter int unsigned DW = 7,
  parameter int unsigned N  = 30,
  parameter int unsigned CW = $clog2(N + 1),
  parameter int unsigned IW = $clog2(N)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Ack,
  input  logic            Descend,
  input  logic [CW-1:0]   Count,
  input  logic [N*DW-1:0] Ain,
  output logic [N*DW-1:0] Aout,
`ifdef SORT_PERM_EN
  output logic [N*IW-1:0] PermOut,
`endif
  output logic            Done,
  output logic            q_Ini,
  output logic            q_Incr,
  output logic            q_Comp,
  output logic            q_Swap,
  output logic            q_Done
);

  logic [StateW-1:0] state_q, state_d;
  logic [DW-1:0]     a_q [N];
  logic [DW-1:0]     a_d [N];
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              desc_q, desc_d;

  // Counters never exceed Count-1 <= N-1, so the low IW bits address the array.
  logic [IW-1:0] k_a, j_a, idx_a;
  assign k_a   = k_q[IW-1:0];
  assign j_a   = j_q[IW-1:0];
  assign idx_a = idx_q[IW-1:0];

  logic [CW-1:0] cnt_clamp;
  assign cnt_clamp = (Count > CW'(N)) ? CW'(N) : Count;

  logic better;

  sort_cmp #(
    .DW(DW)
  ) u_cmp (
    .a      (a_q[j_a]),
    .b      (a_q[idx_a]),
    .descend(desc_q),
    .better (better)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    k_d     = k_q;
    j_d     = j_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    case (state_q)
      StIni: begin
        for (int i = 0; i < N; i++) begin
          a_d[i] = Ain[i*DW +: DW];
        end
        k_d = '0;
        if (Start) begin
          desc_d  = Descend;
          cnt_d   = cnt_clamp;
          state_d = (cnt_clamp < CW'(2)) ? StDone : StIncr;
        end
      end
      StIncr: begin
        j_d     = k_q + CW'(1);
        idx_d   = k_q;
        state_d = StComp;
      end
      StComp: begin
        if (better) begin
          idx_d = j_q;
        end
        if (j_q == cnt_q - CW'(1)) begin
          state_d = StSwap;
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      StSwap: begin
        // When idx_q == k_q both writes carry the same value.
        a_d[k_a]   = a_q[idx_a];
        a_d[idx_a] = a_q[k_a];
        k_d        = k_q + CW'(1);
        state_d    = (k_q == cnt_q - CW'(2)) ? StDone : StIncr;
      end
      StDone: begin
        if (Ack) begin
          state_d = StIni;
        end
      end
      default: state_d = StIni;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIni;
      a_q     <= '{default: '0};
      k_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= OrderAsc;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      k_q     <= k_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
    end
  end

`ifdef SORT_PERM_EN
  logic [IW-1:0] p_q [N];
  logic [IW-1:0] p_d [N];

  // Permutation follows A: identity while loading, swapped alongside A.
  always_comb begin
    p_d = p_q;
    if (state_q == StIni) begin
      for (int i = 0; i < N; i++) begin
        p_d[i] = IW'(i);
      end
    end else if (state_q == StSwap) begin
      p_d[k_a]   = p_q[idx_a];
      p_d[idx_a] = p_q[k_a];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        p_q[i] <= IW'(i);
      end
    end else begin
      p_q <= p_d;
    end
  end

  for (genvar gp = 0; gp < N; gp++) begin : g_perm_out
    assign PermOut[gp*IW +: IW] = p_q[gp];
  end
`else
  // No permutation tracking in this build.
`endif

  for (genvar ga = 0; ga < N; ga++) begin : g_aout
    assign Aout[ga*DW +: DW] = a_q[ga];
  end

  assign q_Ini  = state_q[IniBit];
  assign q_Incr = state_q[IncrBit];
  assign q_Comp = state_q[CompBit];
  assign q_Swap = state_q[SwapBit];
  assign q_Done = state_q[DoneBit];
  assign Done   = state_q[DoneBit];

endmodule

// File: tb/tb_param_selection_sort.sv
// Self-checking bench for param_selection_sort: a driver issues sorts and
// queues the expected result; a monitor checks whenever the DUT presents one.
module tb_param_selection_sort;

  localparam int unsigned DW = 7;
  localparam int unsigned N  = 30;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned AW = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ack;
  logic          descend;
  logic [CW-1:0] count;
  logic [AW-1:0] ain;
  logic [AW-1:0] aout;
  logic          done;
  logic          q_ini, q_incr, q_comp, q_swap, q_done;
`ifdef SORT_PERM_EN
  logic [N*IW-1:0] perm_out;
`endif

  param_selection_sort #(
    .DW(DW),
    .N (N)
  ) dut (
    .Clk    (clk),
    .Reset  (reset),
    .Start  (start),
    .Ack    (ack),
    .Descend(descend),
    .Count  (count),
    .Ain    (ain),
    .Aout   (aout),
`ifdef SORT_PERM_EN
    .PermOut(perm_out),
`endif
    .Done   (done),
    .q_Ini  (q_ini),
    .q_Incr (q_incr),
    .q_Comp (q_comp),
    .q_Swap (q_swap),
    .q_Done (q_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] src_q[$];
  int            lat_q[$];
  int            start_q[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: first n values sorted by value, the rest untouched.
  function automatic logic [AW-1:0] model(input logic [AW-1:0] arr, input int n, input bit desc);
    int q[$];
    logic [AW-1:0] r;
    r = arr;
    for (int i = 0; i < n; i++) q.push_back(int'(arr[i*DW +: DW]));
    if (desc) q.rsort();
    else q.sort();
    for (int i = 0; i < n; i++) r[i*DW +: DW] = DW'(q[i]);
    return r;
  endfunction

  function automatic int lat_of(input int n);
    int l;
    l = 0;
    for (int k = 0; k <= n - 2; k++) l += n + 1 - k;
    return l;
  endfunction

  function automatic logic [AW-1:0] rand_arr();
    logic [AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Monitor: samples just after each rising edge.
  logic          prev_done = 1'b0;
  logic          prev_ini  = 1'b0;
  logic [AW-1:0] held;

  always begin
    logic [AW-1:0] e, s_arr;
    int l, s;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      if (prev_ini && q_ini) chk("ini_follow", aout, ain);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no result pending");
        end else begin
          e     = exp_q.pop_front();
          s_arr = src_q.pop_front();
          l     = lat_q.pop_front();
          s     = start_q.pop_front();
          chk("sorted", aout, e);
          chk("latency", AW'(cyc - s), AW'(l));
          chk("done_flags", AW'({q_ini, q_incr, q_comp, q_swap, q_done}), AW'(5'b00001));
`ifdef SORT_PERM_EN
          for (int i = 0; i < N; i++) begin
            int pi;
            pi = int'(perm_out[i*IW +: IW]);
            if (pi < int'(N)) chk("perm_map", AW'(aout[i*DW +: DW]), AW'(s_arr[pi*DW +: DW]));
            else chk("perm_range", AW'(pi), AW'(N - 1));
          end
`endif
          held = aout;
        end
      end else if (prev_done) begin
        if (ack) begin
          chk("ack_to_ini", AW'({q_ini, done}), AW'(2'b10));
        end else begin
          chk("done_hold", aout, held);
          chk("done_stay", AW'(done), AW'(1'b1));
        end
      end
    end
    prev_done = done;
    prev_ini  = q_ini;
  end

  task automatic wait_done();
    int budget;
    budget = 0;
    while (!done && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", budget);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
    end
  endtask

  task automatic issue(input logic [AW-1:0] arr, input int cnt, input bit desc);
    int n;
    n       = (cnt > int'(N)) ? int'(N) : cnt;
    ain     = arr;
    count   = CW'(cnt);
    descend = desc;
    start   = 1'b1;
    exp_q.push_back(model(arr, n, desc));
    src_q.push_back(arr);
    lat_q.push_back(lat_of(n));
    start_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    ain   = rand_arr();
  endtask

  task automatic run_sort(input logic [AW-1:0] arr, input int cnt, input bit desc,
                          input int ack_wait, input bit chk_perm4);
    @(negedge clk);
    chk("idle_before_start", AW'(q_ini), AW'(1'b1));
    issue(arr, cnt, desc);
    wait_done();
    if (chk_perm4) begin
`ifdef SORT_PERM_EN
      chk("perm_9371", AW'(perm_out[4*IW-1:0]), AW'({IW'(0), IW'(2), IW'(1), IW'(3)}));
`endif
    end
    repeat (ack_wait) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] base, rev;
    int budget;
    reset   = 1'b1;
    start   = 1'b0;
    ack     = 1'b0;
    descend = 1'b0;
    count   = '0;
    ain     = rand_arr();
    #1;
    chk("reset_aout", aout, '0);
    chk("reset_flags", AW'({q_ini, q_incr, q_comp, q_swap, q_done, done}), AW'(6'b100000));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    base = rand_arr();
    base[0*DW +: DW] = DW'(9);
    base[1*DW +: DW] = DW'(3);
    base[2*DW +: DW] = DW'(7);
    base[3*DW +: DW] = DW'(1);
    run_sort(base, 4, 1'b0, 5, 1'b1);
    run_sort(base, 4, 1'b1, 0, 1'b0);
    run_sort(base, 1, 1'b0, 1, 1'b0);
    run_sort(base, 0, 1'b1, 2, 1'b0);

    for (int i = 0; i < int'(N); i++) rev[i*DW +: DW] = DW'(int'(N) - i);
    run_sort(rev, 31, 1'b0, 2, 1'b0);

    // Start and Ack together in DONE: only Ack takes effect.
    @(negedge clk);
    issue(base, 3, 1'b0);
    wait_done();
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    chk("start_ignored_in_done", AW'({q_ini, q_incr, done}), AW'(3'b100));
    start = 1'b0;
    ack   = 1'b0;

    // Reset during COMP aborts at once.
    @(negedge clk);
    issue(rand_arr(), 30, 1'b0);
    budget = 0;
    while (!q_comp && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("reached_comp", AW'(q_comp), AW'(1'b1));
    reset = 1'b1;
    void'(exp_q.pop_back());
    void'(src_q.pop_back());
    void'(lat_q.pop_back());
    void'(start_q.pop_back());
    #1;
    chk("abort_aout", aout, '0);
    chk("abort_flags", AW'({q_ini, q_incr, q_comp, q_swap, q_done, done}), AW'(6'b100000));
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 20; t++) begin
      run_sort(rand_arr(), int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 5)),
               1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", AW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
